// File: rtl/debug_mem_sequencer.sv
// Debug-monitor access sequencer: halts the CPU, performs one word access on
// the instruction or data memory debug port, and returns a one-cycle response.
module debug_mem_sequencer #(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic        cpu_clk,
    input  logic        sys_rstn,
    // Request: accepted on a cycle where req_valid & req_ready are both high;
    // the requester holds all req_* fields until then. Response: rsp_valid is
    // a single-cycle pulse with no backpressure, rsp_error/rsp_rdata qualified by it.
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic        req_imem_p_dmem_n,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic        rsp_error,
    output logic [31:0] rsp_rdata,
    input  logic        debug_hold,
    output logic        halt_req,
    input  logic        halt_ack,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        imem_ce,
    output logic        imem_we,
    output logic        dmem_ce,
    output logic        dmem_we,
    input  logic [31:0] imem_rdata,
    input  logic [31:0] dmem_rdata,
    input  logic        imem_rdata_ready,
    input  logic        dmem_rdata_ready,
    output logic [2:0]  dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_HALT_WAIT = 3'd1,
        S_ACCESS    = 3'd2,
        S_WAIT_DATA = 3'd3,
        S_RESP      = 3'd4
    } state_e;

    localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_e      state_q, state_d;
    logic [15:0] timer_q, timer_d;
    logic        write_q, write_d;
    logic        sel_imem_q, sel_imem_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        err_q, err_d;
    logic [31:0] rdata_q, rdata_d;

    logic        sel_ready;
    logic [31:0] sel_rdata;
    logic        timer_last;
    logic        strobe_active;
    logic        we_active;

    always_ff @(posedge cpu_clk or negedge sys_rstn) begin
        if (!sys_rstn) begin
            state_q    <= S_IDLE;
            timer_q    <= '0;
            write_q    <= 1'b0;
            sel_imem_q <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            err_q      <= 1'b0;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            write_q    <= write_d;
            sel_imem_q <= sel_imem_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            err_q      <= err_d;
            rdata_q    <= rdata_d;
        end
    end

    assign sel_ready  = sel_imem_q ? imem_rdata_ready : dmem_rdata_ready;
    assign sel_rdata  = sel_imem_q ? imem_rdata : dmem_rdata;
    assign timer_last = (timer_q == TIMER_LAST);

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        write_d    = write_q;
        sel_imem_d = sel_imem_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        err_d      = err_q;
        rdata_d    = rdata_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    write_d    = req_write;
                    sel_imem_d = req_imem_p_dmem_n;
                    addr_d     = req_addr;
                    wdata_d    = req_wdata;
                    timer_d    = '0;
                    state_d    = S_HALT_WAIT;
                end
            end
            S_HALT_WAIT: begin
                if (halt_ack) begin
                    state_d = S_ACCESS;
                end else if (timer_last) begin
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end else begin
                    timer_d = timer_q + 16'd1;
                end
            end
            S_ACCESS: begin
                if (!halt_ack) begin
                    err_d   = 1'b1;
                    state_d = S_RESP;
                    if (!write_q) begin
                        rdata_d = '0;
                    end
                end else if (write_q) begin
                    err_d   = 1'b0;
                    state_d = S_RESP;
                end else begin
                    timer_d = '0;
                    state_d = S_WAIT_DATA;
                end
            end
            S_WAIT_DATA: begin
                // Losing the halt outranks data arriving in the same cycle.
                if (!halt_ack) begin
                    err_d   = 1'b1;
                    rdata_d = '0;
                    state_d = S_RESP;
                end else if (sel_ready) begin
                    err_d   = 1'b0;
                    rdata_d = sel_rdata;
                    state_d = S_RESP;
                end else if (timer_last) begin
                    err_d   = 1'b1;
                    rdata_d = '0;
                    state_d = S_RESP;
                end else begin
                    timer_d = timer_q + 16'd1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Strobes are gated by halt_ack so a dropped halt kills them in the same cycle.
    always_comb begin
        strobe_active = ((state_q == S_ACCESS) || (state_q == S_WAIT_DATA)) && halt_ack;
        we_active     = (state_q == S_ACCESS) && halt_ack && write_q;
        imem_ce       = strobe_active && sel_imem_q;
        dmem_ce       = strobe_active && !sel_imem_q;
        imem_we       = we_active && sel_imem_q;
        dmem_we       = we_active && !sel_imem_q;
        req_ready     = (state_q == S_IDLE);
        halt_req      = (state_q != S_IDLE) || debug_hold;
        rsp_valid     = (state_q == S_RESP);
        rsp_error     = (state_q == S_RESP) && err_q;
        rsp_rdata     = rdata_q;
        mem_addr      = addr_q;
        mem_wdata     = wdata_q;
        dbg_state     = state_q;
    end

endmodule
